// File: rtl/rf_sched_pkg.sv
// Shared constants and types for the register-file writeback scheduler.
// Holds default widths and the writeback request record.
package rf_sched_pkg;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int NREQ_MAX = 8;

  typedef logic [ADDR_W-1:0] reg_idx_t;

  typedef struct packed {
    logic              valid;
    reg_idx_t          rd;
    logic [DATA_W-1:0] wdata;
  } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at ptr_i and wraps.
// Produces a one-hot grant plus the binary index of the winner.
module rr_arbiter
  import rf_sched_pkg::*;
#(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] idx_o,
  output logic          any_o
);

  always_comb begin
    int s;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int i = 0; i < N; i++) begin
      s = int'(ptr_i) + i;
      if (s >= N) s = s - N;
      if (!any_o && req_i[s]) begin
        gnt_o[s] = 1'b1;
        idx_o    = PW'(s);
        any_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rf_wb_scheduler.sv
// Arbitrates writeback sources onto the single register-file write port and
// keeps the per-register busy scoreboard used for RAW/WAW hazard detection.
module rf_wb_scheduler
  import rf_sched_pkg::*;
#(
  parameter int NREQ  = 3,
  parameter int WIDTH = DATA_W,
  parameter int ADDR  = ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  iss_valid,
  input  logic [ADDR-1:0]       iss_rd,
  output logic                  iss_ready,
  input  logic [ADDR-1:0]       chk_rs1,
  input  logic [ADDR-1:0]       chk_rs2,
  output logic                  hazard,
  output logic                  idle,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*ADDR-1:0]  req_rd,
  input  logic [NREQ*WIDTH-1:0] req_wdata,
  output logic [NREQ-1:0]       req_ready,
  output logic                  wr_en,
  output logic [ADDR-1:0]       rd,
  output logic [WIDTH-1:0]      wdata
);

  localparam int PW   = $clog2(NREQ);
  localparam int NREG = 2 ** ADDR;

  logic [NREG-1:0]  busy_q, busy_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic             wr_en_q, wr_en_d;
  logic [ADDR-1:0]  rd_q, rd_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;

  logic [NREQ-1:0]  gnt;
  logic [PW-1:0]    gnt_idx;
  logic             gnt_any;
  logic             grant;
  logic [ADDR-1:0]  sel_rd;
  logic [WIDTH-1:0] sel_wdata;
  logic             iss_fire;

  rr_arbiter #(.N(NREQ), .PW(PW)) u_arb (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .any_o (gnt_any)
  );

  // Grants are suppressed during reset so no transfer is consumed while the
  // output stage is being cleared.
  assign req_ready = reset ? '0 : gnt;
  assign grant     = gnt_any & ~reset;

  always_comb begin
    sel_rd    = '0;
    sel_wdata = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt[k]) begin
        sel_rd    = req_rd[k*ADDR +: ADDR];
        sel_wdata = req_wdata[k*WIDTH +: WIDTH];
      end
    end
  end

  assign iss_ready = !busy_q[iss_rd] || (iss_rd == '0);
  assign iss_fire  = iss_valid && iss_ready && (iss_rd != '0);
  assign hazard    = busy_q[chk_rs1] | busy_q[chk_rs2];
  assign idle      = ~(|busy_q) & ~wr_en_q;

  always_comb begin
    busy_d  = busy_q;
    ptr_d   = ptr_q;
    wr_en_d = 1'b0;
    rd_d    = rd_q;
    wdata_d = wdata_q;
    if (grant) begin
      ptr_d   = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
      wr_en_d = (sel_rd != '0);
      rd_d    = sel_rd;
      wdata_d = sel_wdata;
      if (sel_rd != '0) busy_d[sel_rd] = 1'b0;
    end
    // Applied after the clear so a same-cycle issue to the same register wins.
    if (iss_fire) busy_d[iss_rd] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q  <= '0;
      ptr_q   <= '0;
      wr_en_q <= 1'b0;
      rd_q    <= '0;
      wdata_q <= '0;
    end else begin
      busy_q  <= busy_d;
      ptr_q   <= ptr_d;
      wr_en_q <= wr_en_d;
      rd_q    <= rd_d;
      wdata_q <= wdata_d;
    end
  end

  assign wr_en = wr_en_q;
  assign rd    = rd_q;
  assign wdata = wdata_q;

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Directed bench for rf_wb_scheduler: scoreboard, round-robin order,
// x0 handling, WAW stall, set/clear priority and asynchronous reset.
module tb_rf_wb_scheduler;

  localparam int NREQ  = 3;
  localparam int WIDTH = 32;
  localparam int ADDR  = 5;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  iss_valid;
  logic [ADDR-1:0]       iss_rd;
  logic                  iss_ready;
  logic [ADDR-1:0]       chk_rs1;
  logic [ADDR-1:0]       chk_rs2;
  logic                  hazard;
  logic                  idle;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*ADDR-1:0]  req_rd;
  logic [NREQ*WIDTH-1:0] req_wdata;
  logic [NREQ-1:0]       req_ready;
  logic                  wr_en;
  logic [ADDR-1:0]       rd;
  logic [WIDTH-1:0]      wdata;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rf_wb_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH), .ADDR(ADDR)) dut (
    .clk       (clk),
    .reset     (reset),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .iss_ready (iss_ready),
    .chk_rs1   (chk_rs1),
    .chk_rs2   (chk_rs2),
    .hazard    (hazard),
    .idle      (idle),
    .req_valid (req_valid),
    .req_rd    (req_rd),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .wr_en     (wr_en),
    .rd        (rd),
    .wdata     (wdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int k, input logic [ADDR-1:0] r, input logic [WIDTH-1:0] d);
    req_rd[k*ADDR +: ADDR]     = r;
    req_wdata[k*WIDTH +: WIDTH] = d;
  endtask

  initial begin
    reset     = 1'b1;
    iss_valid = 1'b0;
    iss_rd    = '0;
    chk_rs1   = '0;
    chk_rs2   = '0;
    req_valid = '0;
    req_rd    = '0;
    req_wdata = '0;
    tick();
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_rd", 64'(rd), 64'd0);
    chk("rst_wdata", 64'(wdata), 64'd0);
    chk("rst_idle", 64'(idle), 64'd1);
    req_valid = 3'b111;
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    req_valid = '0;
    reset = 1'b0;
    tick();

    // single write of x5 from source 1
    iss_valid = 1'b1; iss_rd = 5'd5; #1;
    chk("iss5_ready", 64'(iss_ready), 64'd1);
    tick();
    iss_valid = 1'b0; chk_rs1 = 5'd5;
    set_src(1, 5'd5, 32'hDEAD_BEEF);
    req_valid = 3'b010; #1;
    chk("x5_hazard_pre", 64'(hazard), 64'd1);
    chk("x5_idle_busy", 64'(idle), 64'd0);
    chk("x5_gnt", 64'(req_ready), 64'b010);
    tick();
    req_valid = '0; #1;
    chk("x5_wr_en", 64'(wr_en), 64'd1);
    chk("x5_rd", 64'(rd), 64'd5);
    chk("x5_wdata", 64'(wdata), 64'hDEAD_BEEF);
    chk("x5_hazard_post", 64'(hazard), 64'd0);
    tick();
    chk("x5_wr_en_drop", 64'(wr_en), 64'd0);
    chk("x5_rd_hold", 64'(rd), 64'd5);
    chk("x5_idle", 64'(idle), 64'd1);

    // x0: issue never blocks, writeback consumed without a write (moves ptr to 0)
    iss_valid = 1'b1; iss_rd = 5'd0; chk_rs1 = 5'd0;
    set_src(2, 5'd0, 32'h1234_5678);
    req_valid = 3'b100; #1;
    chk("x0_iss_ready", 64'(iss_ready), 64'd1);
    chk("x0_gnt", 64'(req_ready), 64'b100);
    tick();
    iss_valid = 1'b0; req_valid = '0; #1;
    chk("x0_wr_en", 64'(wr_en), 64'd0);
    chk("x0_hazard", 64'(hazard), 64'd0);
    chk("x0_idle", 64'(idle), 64'd1);

    // round-robin from pointer 0 with all sources held valid
    set_src(0, 5'd1, 32'h100);
    set_src(1, 5'd2, 32'h101);
    set_src(2, 5'd3, 32'h102);
    req_valid = 3'b111;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("rr_gnt", 64'(req_ready), 64'(1 << (i % 3)));
      tick();
      chk("rr_wr_en", 64'(wr_en), 64'd1);
      chk("rr_rd", 64'(rd), 64'((i % 3) + 1));
      chk("rr_wdata", 64'(wdata), 64'(32'h100 + (i % 3)));
    end
    req_valid = '0;

    // WAW stall on x7
    iss_valid = 1'b1; iss_rd = 5'd7;
    tick();
    #1;
    chk("waw_stall0", 64'(iss_ready), 64'd0);
    tick();
    chk("waw_stall1", 64'(iss_ready), 64'd0);
    set_src(0, 5'd7, 32'h77);
    req_valid = 3'b001; #1;
    chk("waw_gnt", 64'(req_ready), 64'b001);
    chk("waw_stall2", 64'(iss_ready), 64'd0);
    tick();
    req_valid = '0; #1;
    chk("waw_wr_rd", 64'(rd), 64'd7);
    chk("waw_ready", 64'(iss_ready), 64'd1);
    tick();
    chk_rs1 = 5'd7; #1;
    chk("waw_reissue_busy", 64'(iss_ready), 64'd0);
    chk("waw_hazard", 64'(hazard), 64'd1);
    iss_valid = 1'b0;
    set_src(1, 5'd7, 32'h78);
    req_valid = 3'b010;
    tick();
    req_valid = '0; #1;
    chk("waw_clear", 64'(hazard), 64'd0);

    // same-cycle set and clear of x9: set wins
    iss_valid = 1'b1; iss_rd = 5'd9; chk_rs1 = 5'd9;
    set_src(2, 5'd9, 32'h99);
    req_valid = 3'b100; #1;
    chk("sc_gnt", 64'(req_ready), 64'b100);
    tick();
    iss_valid = 1'b0; req_valid = '0; #1;
    chk("sc_busy", 64'(hazard), 64'd1);
    chk("sc_wr_en", 64'(wr_en), 64'd1);
    chk("sc_rd", 64'(rd), 64'd9);
    chk("sc_wdata", 64'(wdata), 64'h99);

    // asynchronous reset mid-operation with x5 and x9 busy
    iss_valid = 1'b1; iss_rd = 5'd5;
    tick();
    iss_valid = 1'b0;
    set_src(0, 5'd1, 32'hA0);
    set_src(1, 5'd2, 32'hA1);
    set_src(2, 5'd3, 32'hA2);
    req_valid = 3'b111;
    tick();
    chk_rs1 = 5'd5; chk_rs2 = 5'd9; #1;
    chk("mid_wr_en_pre", 64'(wr_en), 64'd1);
    chk("mid_hazard_pre", 64'(hazard), 64'd1);
    reset = 1'b1; #1;
    chk("mid_rst_wr_en", 64'(wr_en), 64'd0);
    chk("mid_rst_hazard", 64'(hazard), 64'd0);
    chk("mid_rst_idle", 64'(idle), 64'd1);
    chk("mid_rst_ready", 64'(req_ready), 64'd0);
    tick();
    chk("mid_rst_wr_en_hold", 64'(wr_en), 64'd0);
    reset = 1'b0; #1;
    chk("post_rst_ptr0", 64'(req_ready), 64'b001);
    req_valid = '0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rf_wb_scheduler.md
Name: rf_wb_scheduler

Overview:
- Shares the register file's single write port among NREQ writeback sources (ALU, load unit, CSR/mul) using round-robin arbitration.
- Keeps a per-register busy scoreboard, set at issue and cleared at writeback commit, so decode can detect RAW hazards and stall WAW issue.
- Drives the register file's wr_en/rd/wdata from registered outputs and sits between the execute units and the register file.

Parameters:
- NREQ, 3, number of writeback requesters (2..8).
- WIDTH, 32, data width.
- ADDR, 5, register index width (2**ADDR entries).

Ports:
- clk  in  1  clock, all state on posedge.
- reset  in  1  asynchronous, active-high reset.
- iss_valid  in  1  decode issues an instruction that writes iss_rd.
- iss_rd  in  ADDR  destination register of the issuing instruction.
- iss_ready  out  1  issue accepted; low when busy[iss_rd] is set and iss_rd != 0.
- chk_rs1  in  ADDR  source register 1 to check.
- chk_rs2  in  ADDR  source register 2 to check.
- hazard  out  1  busy[chk_rs1] or busy[chk_rs2]; x0 never busy.
- idle  out  1  no busy bits set and no write pending in the output stage.
- req_valid  in  NREQ  writeback request per source.
- req_rd  in  NREQ*ADDR  destination register per source, packed.
- req_wdata  in  NREQ*WIDTH  write data per source, packed.
- req_ready  out  NREQ  one-hot grant; transfer when valid and ready are both high.
- wr_en  out  1  register file write enable, registered.
- rd  out  ADDR  register file write address, registered.
- wdata  out  WIDTH  register file write data, registered.

Behaviour:
- Reset (asynchronous, active-high):
  - busy clears to 0.
  - Round-robin pointer goes to 0.
  - wr_en, rd and wdata go to 0.
  - req_ready is held at 0 while reset is high.
  - Reset mid-transfer drops the in-flight write; no partial write reaches the register file.
- Arbitration:
  - Combinational round-robin starting at the pointer; at most one req_ready bit is high per cycle.
  - req_ready is only asserted for a source whose req_valid is high; the grant is the transfer.
  - On a grant to source k, the pointer becomes (k+1) mod NREQ. With no grant, the pointer holds.
  - Sources must hold valid, rd and wdata stable until granted.
- Output stage:
  - At the posedge after a grant: wr_en=1, rd=req_rd[k], wdata=req_wdata[k].
  - If the granted rd is 0, the request is consumed but wr_en=0.
  - In a cycle with no grant, the next posedge sets wr_en=0; rd and wdata hold their values.
  - The register file captures on the following negedge, so data is readable within the cycle after the grant.
- Scoreboard:
  - Issue acceptance (iss_valid & iss_ready with iss_rd != 0) sets busy[iss_rd] at the posedge.
  - A grant with req_rd != 0 clears busy[req_rd] at the same posedge that loads the output stage.
  - Hazard therefore deasserts in the cycle the write lands on the negedge; readers sample at the next posedge and see the new value.
  - Set and clear of the same register in the same cycle: set wins. This cannot follow from iss_ready (WAW stall); it is defined for robustness.
  - iss_ready is combinational: !(busy[iss_rd]) or (iss_rd == 0).
  - A writeback to a non-busy register is still written; the busy bit stays 0.
- hazard and idle are combinational from the state registers plus the chk_* inputs.

Decomposition:
- Package rf_sched_pkg holds:
  - Constants ADDR_W=5, DATA_W=32, NREQ_MAX=8.
  - Typedef reg_idx_t (logic [ADDR_W-1:0]).
  - Typedef wb_req_t struct {valid, rd, wdata}.
- Sub-module rr_arbiter (parameter N): inputs req and a pointer, outputs one-hot gnt and the encoded index.
- The scoreboard and output stage stay in rf_wb_scheduler.

Test Plan:
- Reset mid-op: assert reset while req_valid=3'b111 and busy[5]=1 → wr_en=0, busy all 0, idle=1, req_ready=0, immediately (asynchronous).
- Single write: iss x5 accepted, then src1 writes x5=0xDEAD_BEEF → hazard for chk_rs1=5 is 1 until the grant posedge; next cycle wr_en=1, rd=5, wdata=0xDEADBEEF; hazard=0.
- Round-robin fairness: all 3 sources held valid for 6 cycles from pointer 0 → grant order 0,1,2,0,1,2, one write per cycle.
- x0 handling: iss_rd=0 → iss_ready=1 and no busy bit set; writeback rd=0 → req_ready=1, wr_en stays 0, hazard with chk_rs1=0 is 0.
- WAW stall: busy[7]=1, iss_valid with iss_rd=7 → iss_ready=0 until the x7 writeback grant; in the cycle after that grant, iss_ready=1 and the reissue sets busy[7].
- Set/clear same register: force iss accept of x9 and a grant for x9 in the same cycle → busy[9]=1 afterwards and wr_en=1, rd=9.
